mf_disp_wr_arb: RTL

MF_DISP_WR_ARB -- requirements
Module: mf_disp_wr_arb

---
 rtl/mf_disp_wr_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mf_disp_wr_arb.sv
// Write arbiter between the CPU (requester A) and the blitter (requester B).
// It funnels both write streams into the single display address decoder write port.
//
// Ownership is round-robin with a burst limit. An owner keeps the port while it
// requests. It gives the port up after MAX_BURST transfers if the other side is
// waiting. While b_lock is high, B is exempt from that burst limit.
//
// Ports:
//   sys_clk, resetn          clock, asynchronous active-low reset
//   a_req/a_addr/a_data      requester A write request, address, data
//   b_req/b_addr/b_data      requester B write request, address, data
//   b_lock                   B keeps ownership past MAX_BURST while high
//   a_gnt/b_gnt              combinational grant; req & gnt is a transfer
//   sys_wr_vld/addr/data     registered write, one cycle after the transfer
//   arb_owner                current owner: 00 none, 01 A, 10 B
module mf_disp_wr_arb #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        sys_clk,
  input  logic        resetn,
  input  logic        a_req,
  input  logic [15:0] a_addr,
  input  logic [31:0] a_data,
  input  logic        b_req,
  input  logic [15:0] b_addr,
  input  logic [31:0] b_data,
  input  logic        b_lock,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        sys_wr_vld,
  output logic [15:0] sys_wr_addr,
  output logic [31:0] sys_wr_data,
  output logic [1:0]  arb_owner
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwnA = 2'b01,
    StOwnB = 2'b10
  } state_e;

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  state_e      state_q, state_d;
  logic [7:0]  burst_q, burst_d, burst_inc;
  logic        last_b_q, last_b_d;  // 1: B was the owner most recently left
  logic        rst_done_q;
  logic        burst_hit;
  logic        xfer;

  logic        wr_vld_q;
  logic [15:0] wr_addr_q;
  logic [31:0] wr_data_q;

  assign a_gnt     = a_req & (state_q == StOwnA);
  assign b_gnt     = b_req & (state_q == StOwnB);
  assign xfer      = a_gnt | b_gnt;
  assign arb_owner = state_q;

  assign burst_inc = (burst_q == 8'hFF) ? 8'hFF : burst_q + 8'd1;
  // A count already past the limit still forces a hand-over once the other side
  // starts requesting, so an owner that ran alone cannot starve it.
  assign burst_hit = burst_inc >= MaxBurst;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // Hold off for one edge after reset release so the first ownership
        // lands on the second edge.
        if (rst_done_q) begin
          if (a_req && b_req) begin
            state_d = last_b_q ? StOwnA : StOwnB;
          end else if (a_req) begin
            state_d = StOwnA;
          end else if (b_req) begin
            state_d = StOwnB;
          end
        end
      end
      StOwnA: begin
        if (!a_req) begin
          state_d = b_req ? StOwnB : StIdle;
        end else if (burst_hit && b_req) begin
          state_d = StOwnB;
        end
      end
      StOwnB: begin
        if (!b_req) begin
          state_d = a_req ? StOwnA : StIdle;
        end else if (burst_hit && a_req && !b_lock) begin
          state_d = StOwnA;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_b_d = last_b_q;
    burst_d  = burst_q;
    if (state_d != state_q) begin
      burst_d = 8'd0;
      if (state_q == StOwnA) begin
        last_b_d = 1'b0;
      end else if (state_q == StOwnB) begin
        last_b_d = 1'b1;
      end
    end else if (xfer) begin
      burst_d = burst_inc;
    end
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      burst_q    <= 8'd0;
      last_b_q   <= 1'b1;  // A wins the first tie
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      last_b_q   <= last_b_d;
      rst_done_q <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      wr_vld_q  <= 1'b0;
      wr_addr_q <= 16'd0;
      wr_data_q <= 32'd0;
    end else begin
      wr_vld_q <= xfer;
      if (a_gnt) begin
        wr_addr_q <= a_addr;
        wr_data_q <= a_data;
      end else if (b_gnt) begin
        wr_addr_q <= b_addr;
        wr_data_q <= b_data;
      end
    end
  end

  assign sys_wr_vld  = wr_vld_q;
  assign sys_wr_addr = wr_addr_q;
  assign sys_wr_data = wr_data_q;

endmodule
